// File: rtl/odd_one_out_pkg.sv
// Shared types and helpers for the odd-one-out scheduler: default widths,
// FSM state encoding and the round-robin winner search.
package odd_one_out_pkg;

  localparam int W_DEF  = 8;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RESULT = 2'd2
  } state_e;

  // First set bit of req at or after ptr, wrapping modulo nreq (nreq <= 16).
  function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input int          nreq);
    logic [3:0] id;
    logic [4:0] idx;
    id = '0;
    for (int k = 15; k >= 0; k--) begin
      if (k < nreq) begin
        idx = {1'b0, ptr} + 5'(k);
        if (idx >= 5'(nreq)) idx = idx - 5'(nreq);
        if (req[idx[3:0]]) id = idx[3:0];
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/odd_one_out_scheduler_if.sv
// Requester and result-consumer bundle of the odd-one-out scheduler.
interface odd_one_out_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LW   = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    in_valid;
  logic [NREQ*W-1:0]  in_data;
  logic [NREQ-1:0]    in_ready;
  logic [NREQ-1:0]    grant;
  logic               out_valid;
  logic [W-1:0]       out_value;
  logic [IDW-1:0]     out_id;
  logic               out_ready;
  logic               busy;

  modport master (
    output req, req_len, in_valid, in_data, out_ready,
    input  in_ready, grant, out_valid, out_value, out_id, busy
  );

  modport slave (
    input  req, req_len, in_valid, in_data, out_ready,
    output in_ready, grant, out_valid, out_value, out_id, busy
  );
endinterface

// File: rtl/odd_one_out_core.sv
// XOR accumulator datapath; clr wins over en so a fresh job always starts at zero.
module odd_one_out_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/odd_one_out_scheduler.sv
// Round-robin arbiter and job FSM sharing one XOR accumulator among NREQ
// requesters; each result is tagged with the id of the requester that owned it.
module odd_one_out_scheduler
  import odd_one_out_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF,
  parameter int LW   = LW_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic                   clk,
  input logic                   reset,
  odd_one_out_scheduler_if.slave bus
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    outVal_q, outVal_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic            accClr;
  logic            accEn;
  logic [W-1:0]    acc;
  logic [W-1:0]    curData;
  logic [IDW-1:0]  winner;
  logic [LW-1:0]   winLen;
  logic            hs;

  assign winner  = IDW'(rr_pick(16'(bus.req), 4'(ptr_q), NREQ));
  assign winLen  = bus.req_len[winner*LW +: LW];
  assign curData = bus.in_data[gid_q*W +: W];
  assign hs      = (state_q == LOAD) && bus.in_valid[gid_q];

  odd_one_out_core #(.W(W)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (accClr),
    .en    (accEn),
    .din   (curData),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      outVal_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      outVal_q <= outVal_d;
      grant_q  <= grant_d;
    end
  end

  // The final word bypasses the accumulator so the result is ready one cycle
  // after the last handshake.
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    outVal_d = outVal_q;
    grant_d  = grant_q;
    accClr   = 1'b0;
    accEn    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gid_d   = winner;
          len_d   = winLen;
          cnt_d   = '0;
          accClr  = 1'b1;
          grant_d = NREQ'(1) << winner;
          if (winLen == '0) begin
            outVal_d = '0;
            state_d  = RESULT;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          accEn = 1'b1;
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == len_q - LW'(1)) begin
            outVal_d = acc ^ curData;
            state_d  = RESULT;
          end
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == LOAD) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.out_valid = (state_q == RESULT);
  assign bus.out_value = outVal_q;
  assign bus.out_id    = gid_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_odd_one_out_scheduler.sv
// Randomized and directed bench for odd_one_out_scheduler, checked every cycle
// against a job-queue reference model of the round-robin XOR service.
module tb_odd_one_out_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LW   = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  odd_one_out_scheduler_if #(.NREQ(NREQ), .W(W), .LW(LW), .IDW(IDW)) bus ();

  odd_one_out_scheduler #(.NREQ(NREQ), .W(W), .LW(LW), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0]    jobData [NREQ][256];
  int              jobLen  [NREQ];
  logic [NREQ-1:0] reqVec;

  // Reference model: 0 = waiting for a job, 1 = streaming words, 2 = result held
  int           mPhase;
  int           mGid;
  int           mCnt;
  int           mPtr;
  logic [W-1:0] mExp;

  int           validMode;
  int           readyMode;
  int           stallLeft;
  bit           keepReq;
  bit           tgl;
  bit           anyReady;
  int           doneIds[$];
  logic [W-1:0] dutLastVal;
  int           dutLastId;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelPick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] jobXor(input int i);
    logic [W-1:0] x;
    x = '0;
    for (int k = 0; k < jobLen[i]; k++) x = x ^ jobData[i][k];
    return x;
  endfunction

  task automatic newJob(input int i, input int len);
    jobLen[i] = len;
    for (int k = 0; k < 256; k++) jobData[i][k] = W'($urandom);
    reqVec[i] = 1'b1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset         = 1'b1;
    reqVec        = '0;
    bus.req       = '0;
    bus.req_len   = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_grant", 32'(bus.grant), 0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_out_value", 32'(bus.out_value), 0);
    checkOutput("rst_out_id", 32'(bus.out_id), 0);
    reset  = 1'b0;
    mPhase = 0;
    mPtr   = 0;
    mCnt   = 0;
    mGid   = 0;
  endtask

  // One clock: compare outputs with the model, drive inputs, advance the model.
  task automatic applyStimulus();
    logic [NREQ*W-1:0]  dataV;
    logic [NREQ*LW-1:0] lenV;
    logic [NREQ-1:0]    validV;
    @(negedge clk);
    checkOutput("busy", 32'(bus.busy), (mPhase != 0) ? 1 : 0);
    checkOutput("grant", 32'(bus.grant), (mPhase == 0) ? 0 : (1 << mGid));
    checkOutput("in_ready", 32'(bus.in_ready), (mPhase == 1) ? (1 << mGid) : 0);
    checkOutput("out_valid", 32'(bus.out_valid), (mPhase == 2) ? 1 : 0);
    if (mPhase == 2) begin
      checkOutput("out_value", 32'(bus.out_value), 32'(mExp));
      checkOutput("out_id", 32'(bus.out_id), mGid);
    end
    anyReady = anyReady | (bus.in_ready != '0);

    tgl = ~tgl;
    for (int i = 0; i < NREQ; i++) begin
      lenV[i*LW +: LW] = LW'(jobLen[i]);
      dataV[i*W +: W]  = (mPhase == 1 && i == mGid) ? jobData[i][mCnt] : W'($urandom);
    end
    case (validMode)
      0:       validV = '1;
      1:       validV = NREQ'($urandom);
      default: validV = tgl ? '1 : '0;
    endcase
    bus.req      = reqVec;
    bus.req_len  = lenV;
    bus.in_data  = dataV;
    bus.in_valid = validV;
    case (readyMode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom);
      default: begin
        if (mPhase == 2 && stallLeft > 0) begin
          bus.out_ready = 1'b0;
          stallLeft--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
    endcase

    case (mPhase)
      0: begin
        if (reqVec != '0) begin
          mGid   = modelPick(reqVec, mPtr);
          mCnt   = 0;
          mExp   = jobXor(mGid);
          mPhase = (jobLen[mGid] == 0) ? 2 : 1;
        end
      end
      1: begin
        if (validV[mGid]) begin
          mCnt++;
          if (mCnt == jobLen[mGid]) mPhase = 2;
        end
      end
      default: begin
        if (bus.out_ready) begin
          doneIds.push_back(int'(bus.out_id));
          dutLastVal = bus.out_value;
          dutLastId  = int'(bus.out_id);
          mPtr       = (mGid + 1) % NREQ;
          mPhase     = 0;
          if (!keepReq) reqVec[mGid] = 1'b0;
        end
      end
    endcase
  endtask

  task automatic runJobs(input int maxCycles);
    int n;
    n = 0;
    while ((reqVec != '0 || mPhase != 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    if (n >= maxCycles) checkOutput("timeout", 1, 0);
  endtask

  initial begin
    int expOrder[5];
    int n;
    logic [W-1:0] expVal;
    reset     = 1'b1;
    reqVec    = '0;
    validMode = 0;
    readyMode = 0;
    stallLeft = 0;
    keepReq   = 1'b0;
    tgl       = 1'b0;
    anyReady  = 1'b0;
    for (int i = 0; i < NREQ; i++) jobLen[i] = 0;

    $display("[TB] reset with req idle");
    applyReset();
    repeat (3) applyStimulus();

    $display("[TB] single job on requester 0");
    newJob(0, 5);
    jobData[0][0] = 8'd3; jobData[0][1] = 8'd7; jobData[0][2] = 8'd3;
    jobData[0][3] = 8'd9; jobData[0][4] = 8'd7;
    runJobs(100);
    checkOutput("t2_value", 32'(dutLastVal), 9);
    checkOutput("t2_id", dutLastId, 0);

    $display("[TB] round-robin with all requests held");
    applyReset();
    doneIds.delete();
    keepReq = 1'b1;
    for (int i = 0; i < NREQ; i++) newJob(i, 1);
    n = 0;
    while (doneIds.size() < 5 && n < 200) begin
      applyStimulus();
      n++;
    end
    if (n >= 200) checkOutput("t3_timeout", 1, 0);
    keepReq = 1'b0;
    reqVec  = '0;
    runJobs(50);
    expOrder = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t3_order%0d", k), (k < doneIds.size()) ? doneIds[k] : -1, expOrder[k]);
    end

    $display("[TB] backpressure on data and result");
    validMode = 2;
    readyMode = 2;
    stallLeft = 4;
    newJob(1, 6);
    expVal = jobXor(1);
    runJobs(100);
    checkOutput("t4_value", 32'(dutLastVal), 32'(expVal));
    checkOutput("t4_id", dutLastId, 1);

    $display("[TB] zero-length job on requester 2");
    validMode = 0;
    readyMode = 0;
    anyReady  = 1'b0;
    newJob(2, 0);
    runJobs(50);
    checkOutput("t5_no_ready", 32'(anyReady), 0);
    checkOutput("t5_value", 32'(dutLastVal), 0);
    checkOutput("t5_id", dutLastId, 2);

    $display("[TB] reset in the middle of a job");
    newJob(1, 4);
    n = 0;
    while (!(mPhase == 1 && mCnt == 2) && n < 20) begin
      applyStimulus();
      n++;
    end
    if (n >= 20) checkOutput("t6_timeout", 1, 0);
    applyReset();
    repeat (2) applyStimulus();
    newJob(3, 3);
    expVal = jobXor(3);
    runJobs(50);
    checkOutput("t6_value", 32'(dutLastVal), 32'(expVal));
    checkOutput("t6_id", dutLastId, 3);

    $display("[TB] maximum-length job");
    newJob(2, 255);
    expVal = jobXor(2);
    runJobs(400);
    checkOutput("max_value", 32'(dutLastVal), 32'(expVal));

    $display("[TB] randomized traffic");
    validMode = 1;
    readyMode = 1;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, (1 << NREQ) - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (n[i]) newJob(i, $urandom_range(0, 12));
      end
      runJobs(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
